// File: rtl/imem_prog.sv
// imem_prog: run-time programmable instruction memory for the 8-bit CPU.
// Clears itself to NOP_WORD after reset. It then serves registered fetches
// with a latency of one cycle. Its contents can be replaced through a
// sequential load port that always starts at address 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_en, fetch_addr          fetch request (0 = stall) and word address
//   instr, instr_valid            registered fetched word, valid in RUN only
//   load_start                    pulse that begins a load at address 0
//   load_valid, load_data         streamed program word
//   load_last                     marks the final word of the program
//   load_ready                    high while a load is in progress
//   load_count                    words written by the current or last load
//   busy                          high during CLEAR or LOAD
//   parity_err                    stored-parity mismatch on a valid fetch
//                                 (only present when IMEM_PARITY_EN is defined)
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per word
// and to add the parity_err output.
module imem_prog #(
    parameter int unsigned        INSTR_W  = 8,
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DEPTH    = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic [ADDR_W:0]    load_count,
`ifdef IMEM_PARITY_EN
    output logic               parity_err,
`endif
    output logic               busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned WORD_W = INSTR_W + 1;
`else
    localparam int unsigned WORD_W = INSTR_W;
`endif

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;        // shared by the clear and load sequences
    logic [WORD_W-1:0]  mem [DEPTH];

    logic               wr_en;
    logic [INSTR_W-1:0] wr_data;
    logic [WORD_W-1:0]  wr_word;
    logic               addr_ok;
    logic [WORD_W-1:0]  rd_word;
    logic               ptr_at_end;

    assign load_ready = (state == S_LOAD);
    assign busy       = (state != S_RUN);
    assign ptr_at_end = (ptr == IDX_W'(DEPTH - 1));

    // Addresses at or beyond DEPTH read as NOP_WORD.
    assign addr_ok = ((ADDR_W+1)'(fetch_addr) < (ADDR_W+1)'(DEPTH));
    assign rd_word = mem[IDX_W'(fetch_addr)];

    // Write port: CLEAR fills the memory with NOP_WORD, and LOAD writes each accepted word.
    assign wr_en   = !rst && ((state == S_CLEAR) || ((state == S_LOAD) && load_valid));
    assign wr_data = (state == S_CLEAR) ? NOP_WORD : load_data;
`ifdef IMEM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_word;
        end
    end

    // Control FSM and registered fetch path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAR;
            ptr         <= '0;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            load_count  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    instr       <= NOP_WORD;
                    instr_valid <= 1'b0;
                    if (ptr_at_end) begin
                        ptr   <= '0;
                        state <= S_RUN;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                S_RUN: begin
                    if (fetch_en) begin
                        instr       <= addr_ok ? rd_word[INSTR_W-1:0] : NOP_WORD;
                        instr_valid <= 1'b1;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                    // A fetch in the same cycle as load_start is served above.
                    if (load_start) begin
                        state      <= S_LOAD;
                        ptr        <= '0;
                        load_count <= '0;
                    end
                end
                S_LOAD: begin
                    instr       <= NOP_WORD;
                    instr_valid <= 1'b0;
                    if (load_valid) begin
                        ptr        <= ptr + IDX_W'(1);
                        load_count <= load_count + (ADDR_W+1)'(1);
                        // If the last word reaches the end of memory, the load also ends there.
                        if (load_last || ptr_at_end) begin
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

`ifdef IMEM_PARITY_EN
    // Parity flag, aligned with instr; it is zero whenever there is no valid in-range fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (state == S_RUN) && fetch_en && addr_ok && (^rd_word);
        end
    end
`endif

endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: directed test of imem_prog with DEPTH=16. A queue holds the
// expected fetch results. A monitor process pops one entry each time
// instr_valid is seen and compares it with instr.
module tb_imem_prog;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DEPTH   = 16;

    logic               clk;
    logic               rst;
    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               load_start;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic [ADDR_W:0]    load_count;
    logic               busy;
`ifdef IMEM_PARITY_EN
    logic               parity_err;
`endif

    imem_prog #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NOP_WORD(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
`ifdef IMEM_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] prog [13] = '{8'h45, 8'h59, 8'h1B, 8'h2F, 8'h2F, 8'h1A, 8'h2D,
                              8'hC1, 8'h0D, 8'h1E, 8'h6C, 8'h1D, 8'hC2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // The monitor compares every valid fetch with the oldest queued expectation.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got %0h expected none", instr);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch", 32'(instr), 32'(e));
                end
            end
        end
    endtask

    task automatic do_fetch(input logic [7:0] addr, input logic [7:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        exp_q.push_back(exp);
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("run_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int bad_valid;
        rst        = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 8'd3;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();

        // Check the reset state.
        check("rst_instr", 32'(instr), 32'h00);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // The clear sequence keeps busy high for exactly DEPTH cycles.
        rst       = 1'b0;
        cnt       = 0;
        bad_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cnt++;
            if (instr_valid) bad_valid++;
            tick();
        end
        check("clear_cycles", 32'(cnt), 32'd16);
        check("clear_valid_low", 32'(bad_valid), 32'd0);
        check("run_entry_valid", 32'(instr_valid), 32'd0);
        exp_q.push_back(8'h00);     // addr 3 is still being fetched
        tick();
        fetch_en = 1'b0;

        // Load the program.
        start_load();
        check("load_ready", 32'(load_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 13; i++) begin
            if (i == 12) check("busy_before_last", 32'(busy), 32'd1);
            load_word(prog[i], i == 12);
        end
        check("busy_after_last", 32'(busy), 32'd0);
        check("load_count_13", 32'(load_count), 32'd13);
        do_fetch(8'd0, 8'h45);
        do_fetch(8'd2, 8'h1B);
        do_fetch(8'd7, 8'hC1);
        do_fetch(8'd12, 8'hC2);
        do_fetch(8'd13, 8'h00);

        // Stall: instr holds while fetch_addr moves.
        do_fetch(8'd7, 8'hC1);
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 8'(2 + i * 3);
            tick();
            check("stall_instr", 32'(instr), 32'hC1);
            check("stall_valid", 32'(instr_valid), 32'd0);
        end

        // Gaps in load_valid: only valid beats are written.
        start_load();
        begin
            logic       v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            logic [7:0] d [5] = '{8'hA1, 8'hFF, 8'hEE, 8'hA2, 8'hA3};
            for (int i = 0; i < 5; i++) begin
                load_valid = v[i];
                load_data  = d[i];
                load_last  = (i == 4);
                tick();
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("gap_busy", 32'(busy), 32'd0);
        check("gap_count", 32'(load_count), 32'd3);
        do_fetch(8'd0, 8'hA1);
        do_fetch(8'd1, 8'hA2);
        do_fetch(8'd2, 8'hA3);
        do_fetch(8'd3, 8'h2F);

        // Overflow: a load without load_last stops after DEPTH words.
        start_load();
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(8'h80 + i);
            load_last  = 1'b0;
            tick();
            if (i == 15) begin
                check("ovf_busy", 32'(busy), 32'd0);
                check("ovf_count", 32'(load_count), 32'd16);
            end
        end
        load_valid = 1'b0;
        check("ovf_count_hold", 32'(load_count), 32'd16);
        do_fetch(8'd0, 8'h80);
        do_fetch(8'd14, 8'h8E);
        do_fetch(8'd15, 8'h8F);
        do_fetch(8'd20, 8'h00);
        do_fetch(8'd255, 8'h00);

        // Reset mid-load: the memory is fully re-cleared.
        start_load();
        for (int i = 0; i < 5; i++) load_word(8'(8'hC0 + i), 1'b0);
        check("mid_count", 32'(load_count), 32'd5);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_count", 32'(load_count), 32'd0);
        rst = 1'b0;
        wait_run();
        check("post_clear_count", 32'(load_count), 32'd0);
        for (int a = 0; a < 16; a++) do_fetch(8'(a), 8'h00);

        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef IMEM_PARITY_EN
        check("parity_err", 32'(parity_err), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
